// File: rtl/instr_fetch_responder.sv
// Fetch responder for the program counter: assembles a 32-bit big-endian
// instruction from four byte reads on a req/ack memory bus, holds the PC via a
// combinational busy, and reports bad requests or memory stalls with fetch_err.
`timescale 1ns/1ps

module instr_fetch_responder #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [2:0]  access_size,
  output logic        busy,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_err,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [31:0]      cur_pc_reg, cur_pc_next;
  logic [31:0]      last_pc_reg, last_pc_next;
  logic             first_reg, first_next;
  logic [1:0]       byte_idx_reg, byte_idx_next;
  logic [31:0]      shift_reg, shift_next;
  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic [31:0]      mem_addr_reg, mem_addr_next;
  logic             mem_req_reg, mem_req_next;
  logic [31:0]      instr_reg, instr_next;
  logic             instr_valid_reg, instr_valid_next;
  logic             fetch_err_reg, fetch_err_next;

  logic pc_new;
  logic req_bad;
  logic redirect;

  // A request is new on the first cycle after reset or whenever pc moves.
  assign pc_new   = first_reg | (pc != last_pc_reg);
  // Only aligned word fetches are supported.
  assign req_bad  = (pc[1:0] != 2'b00) | (access_size != 3'd0);
  // The PC moved away from the address currently being assembled.
  assign redirect = (pc != cur_pc_reg);

  // Combinational so a PC change is held on the very next edge.
  assign busy = !reset & ((state_reg == FETCH) | pc_new);

  assign instr       = instr_reg;
  assign instr_valid = instr_valid_reg;
  assign fetch_err   = fetch_err_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_req     = mem_req_reg;

  // Next-state logic: request decode in IDLE, byte handshake and timeout in FETCH.
  always_comb begin
    state_next       = state_reg;
    cur_pc_next      = cur_pc_reg;
    last_pc_next     = last_pc_reg;
    first_next       = first_reg;
    byte_idx_next    = byte_idx_reg;
    shift_next       = shift_reg;
    tmo_cnt_next     = tmo_cnt_reg;
    mem_addr_next    = mem_addr_reg;
    mem_req_next     = mem_req_reg;
    instr_next       = instr_reg;
    instr_valid_next = 1'b0;
    fetch_err_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pc_new) begin
          // Latch the address even when rejected so a bad pc is not retried.
          last_pc_next = pc;
          first_next   = 1'b0;
          if (req_bad) begin
            fetch_err_next = 1'b1;
          end else begin
            cur_pc_next   = pc;
            byte_idx_next = 2'd0;
            mem_addr_next = pc;
            mem_req_next  = 1'b1;
            tmo_cnt_next  = '0;
            state_next    = FETCH;
          end
        end
      end

      FETCH: begin
        if (mem_ack) begin
          tmo_cnt_next = '0;
          if (redirect) begin
            // The byte just acked belongs to the abandoned address: drop it.
            cur_pc_next   = pc;
            last_pc_next  = pc;
            byte_idx_next = 2'd0;
            if (req_bad) begin
              mem_req_next   = 1'b0;
              fetch_err_next = 1'b1;
              state_next     = IDLE;
            end else begin
              mem_addr_next = pc;
            end
          end else begin
            shift_next = {shift_reg[23:0], mem_rdata};
            if (byte_idx_reg != 2'd3) begin
              // Keep mem_req high so the next byte follows without a bubble.
              byte_idx_next = byte_idx_reg + 2'd1;
              mem_addr_next = cur_pc_reg + {30'd0, byte_idx_reg} + 32'd1;
            end else begin
              instr_next       = {shift_reg[23:0], mem_rdata};
              instr_valid_next = 1'b1;
              mem_req_next     = 1'b0;
              state_next       = IDLE;
            end
          end
        end else if (tmo_cnt_reg == TMO_LAST) begin
          // Memory stalled too long; last_pc keeps the address so no auto-retry.
          mem_req_next   = 1'b0;
          fetch_err_next = 1'b1;
          state_next     = IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset; reset abandons any transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      cur_pc_reg      <= 32'd0;
      last_pc_reg     <= 32'd0;
      first_reg       <= 1'b1;
      byte_idx_reg    <= 2'd0;
      shift_reg       <= 32'd0;
      tmo_cnt_reg     <= '0;
      mem_addr_reg    <= 32'd0;
      mem_req_reg     <= 1'b0;
      instr_reg       <= 32'd0;
      instr_valid_reg <= 1'b0;
      fetch_err_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cur_pc_reg      <= cur_pc_next;
      last_pc_reg     <= last_pc_next;
      first_reg       <= first_next;
      byte_idx_reg    <= byte_idx_next;
      shift_reg       <= shift_next;
      tmo_cnt_reg     <= tmo_cnt_next;
      mem_addr_reg    <= mem_addr_next;
      mem_req_reg     <= mem_req_next;
      instr_reg       <= instr_next;
      instr_valid_reg <= instr_valid_next;
      fetch_err_reg   <= fetch_err_next;
    end
  end

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Self-checking bench for instr_fetch_responder: table of fetch vectors,
// hand-written redirect/timeout/reset sequences, and random fetches checked
// against a transaction-level model of latency, bus traffic and results.
`timescale 1ns/1ps

module tb_instr_fetch_responder;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [2:0]  access_size;
  logic        busy;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_err;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  instr_fetch_responder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .access_size (access_size),
    .busy        (busy),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fetch_err   (fetch_err),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] busy_m;
    logic [31:0] req_m;
    logic [31:0] valid_m;
    logic [31:0] err_m;
    logic [31:0] got_instr;
    logic [31:0] probe_instr;
    logic [31:0] final_instr;
  } win_t;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  asz;
    int          w;
    bit          err;
    logic [31:0] instr;
    int          lat;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // memory responder state
  int          wait_cfg = 0;
  int          wait_ctr = 0;
  bit          ack_block = 1'b0;
  logic [31:0] hold_addr = 32'd0;
  int          stab_bad = 0;
  logic [31:0] xfer_q[$];

  // per-cycle observations
  logic        obs_busy, obs_req, obs_valid, obs_err;
  logic [31:0] obs_addr, obs_instr;

  // reference model state
  logic [31:0] model_last = 32'd0;
  logic [31:0] model_instr = 32'd0;
  bit          model_first = 1'b1;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h8002_0000: return 8'h3C;
      32'h8002_0001: return 8'h08;
      32'h8002_0002: return 8'h80;
      32'h8002_0003: return 8'h01;
      32'h8002_0004: return 8'h27;
      32'h8002_0005: return 8'hBD;
      32'h8002_0006: return 8'hFF;
      32'h8002_0007: return 8'hE0;
      32'hFFFF_FFFC: return 8'hDE;
      32'hFFFF_FFFD: return 8'hAD;
      32'hFFFF_FFFE: return 8'hBE;
      32'hFFFF_FFFF: return 8'hEF;
      32'h0000_0000: return 8'h01;
      32'h0000_0001: return 8'h23;
      32'h0000_0002: return 8'h45;
      32'h0000_0003: return 8'h67;
      default: return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5 ^ {a[1:0], a[1:0], a[1:0], a[1:0]};
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a), mem_byte(a + 32'd1), mem_byte(a + 32'd2), mem_byte(a + 32'd3)};
  endfunction

  function automatic logic [31:0] below(input int n);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < n && k < 32; k++) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] bitm(input int n);
    return 32'd1 << n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_xfers(input string name, input logic [31:0] exp_q[$]);
    chk({name, "_xfer_count"}, 32'(xfer_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < xfer_q.size(); k++)
      chk($sformatf("%s_xfer%0d", name, k), xfer_q[k], exp_q[k]);
  endtask

  // One clock cycle: answer the bus, observe outputs, advance past the edge.
  task automatic run_cycle();
    if (mem_req === 1'b1 && !ack_block && !reset) begin
      if (wait_ctr == 0) hold_addr = mem_addr;
      else if (mem_addr != hold_addr) stab_bad++;
      if (wait_ctr >= wait_cfg) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_byte(mem_addr);
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
      end
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 8'($urandom);
    end
    #1;
    obs_busy  = busy;
    obs_req   = mem_req;
    obs_addr  = mem_addr;
    obs_valid = instr_valid;
    obs_err   = fetch_err;
    obs_instr = instr;
    if (mem_req === 1'b1 && mem_ack && !reset) xfer_q.push_back(mem_addr);
    if (reset || mem_req !== 1'b1 || mem_ack) wait_ctr = 0;
    else wait_ctr++;
    @(posedge clk);
    #1;
  endtask

  // Run a window of cycles, recording per-cycle output traces as bit masks.
  task automatic window(input int ncyc, input int chg_at, input logic [31:0] chg_pc,
                        input int rst_at, input int probe_at, output win_t s);
    s = '{default: '0};
    for (int c = 0; c < ncyc; c++) begin
      if (c == chg_at) pc = chg_pc;
      reset = (c == rst_at);
      run_cycle();
      s.busy_m[c]  = obs_busy;
      s.req_m[c]   = obs_req;
      s.valid_m[c] = obs_valid;
      s.err_m[c]   = obs_err;
      if (obs_valid) s.got_instr = obs_instr;
      if (c == probe_at) s.probe_instr = obs_instr;
      s.final_instr = obs_instr;
    end
    reset = 1'b0;
  endtask

  task automatic do_fetch(input string name, input logic [31:0] a, input logic [2:0] asz,
                          input int w, input bit exp_err, input logic [31:0] exp_instr,
                          input int exp_lat);
    win_t        s;
    logic [31:0] exp_q[$];
    bit          ok_fetch;
    ok_fetch    = (exp_lat != 0) && !exp_err;
    access_size = asz;
    wait_cfg    = w;
    xfer_q.delete();
    stab_bad    = 0;
    window(exp_lat + 3, 0, a, -1, -1, s);
    if (exp_lat != 0) begin
      model_last  = a;
      model_first = 1'b0;
    end
    if (ok_fetch) model_instr = exp_instr;
    chk({name, "_busy"},  s.busy_m,  below(exp_lat));
    chk({name, "_valid"}, s.valid_m, ok_fetch ? bitm(exp_lat) : 32'd0);
    chk({name, "_err"},   s.err_m,   exp_err ? bitm(1) : 32'd0);
    chk({name, "_req"},   s.req_m,   ok_fetch ? (below(exp_lat) & ~32'd1) : 32'd0);
    if (ok_fetch) begin
      chk({name, "_instr"}, s.got_instr, exp_instr);
      for (int k = 0; k < 4; k++) exp_q.push_back(a + 32'(k));
      chk({name, "_addr_stable"}, 32'(stab_bad), 32'd0);
    end
    chk_xfers(name, exp_q);
    chk({name, "_hold"}, s.final_instr, model_instr);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[7];
    win_t        s;
    logic [31:0] exp_q[$];
    logic [31:0] a, b;

    tbl[0] = '{32'h8002_0000, 3'd0, 0, 1'b0, 32'h3C08_8001, 5};
    tbl[1] = '{32'h8002_0004, 3'd0, 2, 1'b0, 32'h27BD_FFE0, 13};
    tbl[2] = '{32'h8002_0002, 3'd0, 0, 1'b1, 32'h0, 1};
    tbl[3] = '{32'h8002_0008, 3'd1, 0, 1'b1, 32'h0, 1};
    tbl[4] = '{32'h8002_0008, 3'd0, 1, 1'b0, 32'h0, 0};
    tbl[5] = '{32'hFFFF_FFFC, 3'd0, 1, 1'b0, 32'hDEAD_BEEF, 9};
    tbl[6] = '{32'h0000_0000, 3'd0, 3, 1'b0, 32'h0123_4567, 17};

    reset = 1'b1; pc = 32'd0; access_size = 3'd0; mem_ack = 1'b0; mem_rdata = 8'd0;
    @(posedge clk);
    #1;
    run_cycle();
    run_cycle();
    chk("reset_busy",  32'(obs_busy),  32'd0);
    chk("reset_req",   32'(obs_req),   32'd0);
    chk("reset_addr",  obs_addr,       32'd0);
    chk("reset_instr", obs_instr,      32'd0);
    chk("reset_valid", 32'(obs_valid), 32'd0);
    chk("reset_err",   32'(obs_err),   32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      do_fetch($sformatf("vec%0d", i), tbl[i].pc, tbl[i].asz, tbl[i].w,
               tbl[i].err, tbl[i].instr, tbl[i].lat);
      $display("vec%0d pc=%h asz=%0d wait=%0d instr=%h", i, tbl[i].pc, tbl[i].asz, tbl[i].w, instr);
    end

    // Redirect after byte 1 acked: byte 2 completes at the old address, then restart.
    a = 32'h8002_0040; b = 32'h8000_0100;
    pc = a; access_size = 3'd0; wait_cfg = 1; xfer_q.delete(); stab_bad = 0;
    window(19, 5, b, -1, -1, s);
    model_last = b; model_instr = mem_word(b);
    chk("redir_busy",  s.busy_m,  below(15));
    chk("redir_valid", s.valid_m, bitm(15));
    chk("redir_err",   s.err_m,   32'd0);
    chk("redir_req",   s.req_m,   below(15) & ~32'd1);
    chk("redir_instr", s.got_instr, mem_word(b));
    exp_q.delete();
    for (int k = 0; k < 3; k++) exp_q.push_back(a + 32'(k));
    for (int k = 0; k < 4; k++) exp_q.push_back(b + 32'(k));
    chk_xfers("redir", exp_q);
    $display("redirect %h->%h instr=%h", a, b, s.got_instr);

    // Timeout: memory never acks.
    a = 32'h8002_0060;
    ack_block = 1'b1; xfer_q.delete();
    window(10, 0, a, -1, -1, s);
    model_last = a;
    chk("tmo_busy",  s.busy_m,  below(5));
    chk("tmo_req",   s.req_m,   below(5) & ~32'd1);
    chk("tmo_err",   s.err_m,   bitm(5));
    chk("tmo_valid", s.valid_m, 32'd0);
    ack_block = 1'b0;
    window(6, -1, 32'd0, -1, -1, s);
    chk("tmo_noretry_req",  s.req_m,  32'd0);
    chk("tmo_noretry_busy", s.busy_m, 32'd0);
    chk("tmo_hold", s.final_instr, model_instr);
    $display("timeout pc=%h err_mask=%h", a, s.err_m);

    // Reset in the cycle after byte 2 acked; current pc is refetched from byte 0.
    a = 32'h8002_0070;
    wait_cfg = 0; xfer_q.delete();
    window(14, 0, a, 4, 5, s);
    model_last = a; model_first = 1'b0; model_instr = mem_word(a);
    chk("rst_busy",  s.busy_m,  below(10) & ~bitm(4));
    chk("rst_req",   s.req_m,   below(10) & ~bitm(0) & ~bitm(5));
    chk("rst_valid", s.valid_m, bitm(10));
    chk("rst_err",   s.err_m,   32'd0);
    chk("rst_instr_cleared", s.probe_instr, 32'd0);
    chk("rst_instr", s.got_instr, mem_word(a));
    exp_q.delete();
    for (int k = 0; k < 3; k++) exp_q.push_back(a + 32'(k));
    for (int k = 0; k < 4; k++) exp_q.push_back(a + 32'(k));
    chk_xfers("rst", exp_q);
    $display("reset-mid-fetch pc=%h instr=%h", a, s.got_instr);

    // Random fetches against the transaction-level model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra;
      logic [2:0]  rasz;
      int          rw, sel, lat;
      bit          is_new, bad;
      sel = int'($urandom_range(0, 9));
      if (sel == 0) ra = model_last;
      else if (sel == 1) begin
        ra = $urandom();
        if (ra[1:0] == 2'b00) ra[0] = 1'b1;
      end else if (sel == 2) ra = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
      else ra = $urandom() & ~32'h3;
      rasz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      rw = int'($urandom_range(0, 3));
      is_new = model_first || (ra != model_last);
      bad = (ra[1:0] != 2'b00) || (rasz != 3'd0);
      lat = !is_new ? 0 : (bad ? 1 : 1 + 4 * (rw + 1));
      do_fetch($sformatf("rand%0d", i), ra, rasz, rw, bad && is_new, mem_word(ra), lat);
      $display("rand%0d pc=%h asz=%0d wait=%0d lat=%0d instr=%h", i, ra, rasz, rw, lat, instr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
